// File: rtl/softmax_cfg_pkg.sv
// Shared definitions for the softmax configuration master: slave register
// map, CSR_STATE bit positions, check pattern and sequencer states.
// Build option: SOFTMAX_CFG_CHECK_EN adds the CSR_CHECK read state.
package softmax_cfg_pkg;

  localparam int unsigned REG_AW = 6;

  localparam logic [REG_AW-1:0] RD_ADDR          = 6'h00;
  localparam logic [REG_AW-1:0] WR_ADDR          = 6'h01;
  localparam logic [REG_AW-1:0] IO_LEN           = 6'h02;
  localparam logic [REG_AW-1:0] END_OF_IN_CONFIG = 6'h20;
  localparam logic [REG_AW-1:0] CSR_STATE        = 6'h21;
  localparam logic [REG_AW-1:0] CSR_TIME         = 6'h22;
  localparam logic [REG_AW-1:0] CSR_CHECK        = 6'h3F;

  // Value the slave must return from CSR_CHECK before it is programmed.
  localparam logic [31:0] CHECK_PATTERN = 32'hF0F0_F0F0;

  // CSR_STATE bit positions.
  localparam int unsigned CSR_STATE_DONE = 0;
  localparam int unsigned CSR_STATE_BUSY = 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
`ifdef SOFTMAX_CFG_CHECK_EN
    ST_CHECK_RD  = 4'd11,
`endif
    ST_WR_DISARM = 4'd1,
    ST_WR_RADDR  = 4'd2,
    ST_WR_WADDR  = 4'd3,
    ST_WR_IOLEN  = 4'd4,
    ST_WR_ARM    = 4'd5,
    ST_POLL_RD   = 4'd6,
    ST_POLL_CHK  = 4'd7,
    ST_POLL_WAIT = 4'd8,
    ST_TIME_RD   = 4'd9,
    ST_FINISH    = 4'd10
  } cfg_state_e;

endpackage

// File: rtl/softmax_cfg_poll_timer.sv
// Poll pacing for the configuration master: a gap counter that spaces
// CSR_STATE reads POLL_GAP cycles apart, and a read counter that flags the
// timeout once POLL_MAX reads have been issued.
module softmax_cfg_poll_timer #(
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic gap_load,
  input  logic gap_tick,
  output logic gap_expired,
  input  logic poll_clr,
  input  logic poll_inc,
  output logic poll_expired
);

  localparam int GW         = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW         = $clog2(POLL_MAX + 1);
  localparam int GAP_LOAD_I = (POLL_GAP > 0) ? (POLL_GAP - 1) : 0;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LOAD_I);
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

  logic [GW-1:0] gap_cnt_r;
  logic [PW-1:0] poll_cnt_r;

  // Gap counter: loaded so that the wait state lasts exactly POLL_GAP cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt_r <= '0;
    end else if (gap_load) begin
      gap_cnt_r <= GAP_LOAD;
    end else if (gap_tick && (gap_cnt_r != '0)) begin
      gap_cnt_r <= gap_cnt_r - GW'(1);
    end else begin
      gap_cnt_r <= gap_cnt_r;
    end
  end

  // Read counter: one step per CSR_STATE read, cleared on each new sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt_r <= '0;
    end else if (poll_clr) begin
      poll_cnt_r <= '0;
    end else if (poll_inc && !poll_expired) begin
      poll_cnt_r <= poll_cnt_r + PW'(1);
    end else begin
      poll_cnt_r <= poll_cnt_r;
    end
  end

  assign gap_expired  = (gap_cnt_r == '0);
  assign poll_expired = (poll_cnt_r >= POLL_LIM);

endmodule

// File: rtl/softmax_config_master.sv
// Softmax configuration master: programs RD_ADDR/WR_ADDR/IO_LEN, arms the
// core via END_OF_IN_CONFIG, polls CSR_STATE until done (or timeout) and
// returns CSR_TIME. Every bus output is registered for the state being
// entered, so each transaction is visible in the cycle its state occupies.
// Build option: SOFTMAX_CFG_CHECK_EN reads CSR_CHECK before programming.
module softmax_config_master
  import softmax_cfg_pkg::*;
#(
  parameter int DW       = 32,
  parameter int CW       = 6,
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic [DW-1:0] cfg_raddr,
  input  logic [DW-1:0] cfg_waddr,
  input  logic [CW-1:0] cfg_iolen,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [DW-1:0] cfg_time,
  output logic          config_ena,
  output logic [CW-1:0] config_addr,
  output logic [DW-1:0] config_wdata,
  input  logic [DW-1:0] config_rdata
);

  localparam logic [CW-1:0] A_RD    = CW'(RD_ADDR);
  localparam logic [CW-1:0] A_WR    = CW'(WR_ADDR);
  localparam logic [CW-1:0] A_LEN   = CW'(IO_LEN);
  localparam logic [CW-1:0] A_EOC   = CW'(END_OF_IN_CONFIG);
  localparam logic [CW-1:0] A_STATE = CW'(CSR_STATE);
  localparam logic [CW-1:0] A_TIME  = CW'(CSR_TIME);
`ifdef SOFTMAX_CFG_CHECK_EN
  localparam logic [CW-1:0] A_CHECK = CW'(CSR_CHECK);
`endif

  cfg_state_e    state_r;
  logic          phase_r;      // 0: first read cycle, 1: sample cycle
  logic          done_seen_r;  // CSR_STATE.DONE from the latest poll
  logic [DW-1:0] raddr_r;
  logic [DW-1:0] waddr_r;
  logic [CW-1:0] iolen_r;

  logic gap_load_s;
  logic gap_tick_s;
  logic gap_expired_s;
  logic poll_clr_s;
  logic poll_inc_s;
  logic poll_expired_s;

  softmax_cfg_poll_timer #(
    .POLL_GAP (POLL_GAP),
    .POLL_MAX (POLL_MAX)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .gap_load     (gap_load_s),
    .gap_tick     (gap_tick_s),
    .gap_expired  (gap_expired_s),
    .poll_clr     (poll_clr_s),
    .poll_inc     (poll_inc_s),
    .poll_expired (poll_expired_s)
  );

  // Timer controls decoded from the current state.
  always_comb begin
    gap_load_s = 1'b0;
    gap_tick_s = 1'b0;
    poll_clr_s = 1'b0;
    poll_inc_s = 1'b0;
    case (state_r)
      ST_IDLE:      poll_clr_s = cfg_start;
      ST_POLL_RD:   poll_inc_s = phase_r;
      ST_POLL_CHK:  gap_load_s = !done_seen_r && !poll_expired_s;
      ST_POLL_WAIT: gap_tick_s = !gap_expired_s;
      default:      gap_load_s = 1'b0;
    endcase
  end

  // Sequencer: picks the next state and registers its bus/host outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      phase_r      <= 1'b0;
      done_seen_r  <= 1'b0;
      raddr_r      <= '0;
      waddr_r      <= '0;
      iolen_r      <= '0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
      cfg_time     <= '0;
      config_ena   <= 1'b0;
      config_addr  <= '0;
      config_wdata <= '0;
    end else begin
      config_ena   <= 1'b0;
      config_addr  <= '0;
      config_wdata <= '0;
      cfg_done     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            raddr_r  <= cfg_raddr;
            waddr_r  <= cfg_waddr;
            iolen_r  <= cfg_iolen;
            cfg_busy <= 1'b1;
            cfg_err  <= 1'b0;
            cfg_time <= '0;
`ifdef SOFTMAX_CFG_CHECK_EN
            state_r     <= ST_CHECK_RD;
            config_addr <= A_CHECK;
            phase_r     <= 1'b0;
`else
            // Writing 0 first re-arms the slave's END_OF_IN_CONFIG edge detector.
            state_r      <= ST_WR_DISARM;
            config_ena   <= 1'b1;
            config_addr  <= A_EOC;
            config_wdata <= '0;
`endif
          end
        end
`ifdef SOFTMAX_CFG_CHECK_EN
        ST_CHECK_RD: begin
          if (!phase_r) begin
            config_addr <= A_CHECK;
            phase_r     <= 1'b1;
          end else if (config_rdata == DW'(CHECK_PATTERN)) begin
            state_r      <= ST_WR_DISARM;
            config_ena   <= 1'b1;
            config_addr  <= A_EOC;
            config_wdata <= '0;
          end else begin
            state_r  <= ST_FINISH;
            cfg_err  <= 1'b1;
            cfg_done <= 1'b1;
          end
        end
`endif
        ST_WR_DISARM: begin
          state_r      <= ST_WR_RADDR;
          config_ena   <= 1'b1;
          config_addr  <= A_RD;
          config_wdata <= raddr_r;
        end
        ST_WR_RADDR: begin
          state_r      <= ST_WR_WADDR;
          config_ena   <= 1'b1;
          config_addr  <= A_WR;
          config_wdata <= waddr_r;
        end
        ST_WR_WADDR: begin
          state_r      <= ST_WR_IOLEN;
          config_ena   <= 1'b1;
          config_addr  <= A_LEN;
          config_wdata <= DW'(iolen_r);
        end
        ST_WR_IOLEN: begin
          state_r      <= ST_WR_ARM;
          config_ena   <= 1'b1;
          config_addr  <= A_EOC;
          config_wdata <= DW'(1);
        end
        ST_WR_ARM: begin
          state_r     <= ST_POLL_RD;
          config_addr <= A_STATE;
          phase_r     <= 1'b0;
        end
        ST_POLL_RD: begin
          if (!phase_r) begin
            config_addr <= A_STATE;
            phase_r     <= 1'b1;
          end else begin
            done_seen_r <= config_rdata[CSR_STATE_DONE];
            state_r     <= ST_POLL_CHK;
          end
        end
        ST_POLL_CHK: begin
          if (done_seen_r) begin
            state_r     <= ST_TIME_RD;
            config_addr <= A_TIME;
            phase_r     <= 1'b0;
          end else if (poll_expired_s) begin
            state_r  <= ST_FINISH;
            cfg_err  <= 1'b1;
            cfg_done <= 1'b1;
          end else if (POLL_GAP == 0) begin
            state_r     <= ST_POLL_RD;
            config_addr <= A_STATE;
            phase_r     <= 1'b0;
          end else begin
            state_r <= ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
          if (gap_expired_s) begin
            state_r     <= ST_POLL_RD;
            config_addr <= A_STATE;
            phase_r     <= 1'b0;
          end else begin
            state_r <= ST_POLL_WAIT;
          end
        end
        ST_TIME_RD: begin
          if (!phase_r) begin
            config_addr <= A_TIME;
            phase_r     <= 1'b1;
          end else begin
            cfg_time <= config_rdata;
            cfg_done <= 1'b1;
            state_r  <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          cfg_busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          cfg_busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_config_master.sv
// Directed bench for softmax_config_master with a behavioural config slave.
// Honours SOFTMAX_CFG_CHECK_EN (adds the CSR_CHECK read and its failure case).
module tb_softmax_config_master;

  localparam int GAP  = 4;
  localparam int PMAX = 8;
`ifdef SOFTMAX_CFG_CHECK_EN
  localparam int CHK = 2;
`else
  localparam int CHK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [31:0] cfg_raddr;
  logic [31:0] cfg_waddr;
  logic [5:0]  cfg_iolen;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [31:0] cfg_time;
  logic        config_ena;
  logic [5:0]  config_addr;
  logic [31:0] config_wdata;
  logic [31:0] config_rdata = 32'h0;

  // Slave model knobs.
  int          done_on;    // poll number that first reports DONE (0: never)
  logic [31:0] slv_time;
  logic [31:0] chk_val;
  logic        clr_mon;

  // Monitor state.
  typedef struct { logic [5:0] addr; logic [31:0] data; int cyc; } wr_t;
  wr_t  wr_log[$];
  int   poll_log[$];
  int   cyc = 0;
  int   poll_cnt_r = 0;
  int   eoc_pulse_r = 0;
  int   done_cnt_r = 0;
  logic eoc_r = 1'b0;
  logic [5:0] prev_addr_r = 6'h0;

  int n_cmp = 0;
  int n_fail = 0;

  softmax_config_master #(
    .DW(32), .CW(6), .POLL_GAP(GAP), .POLL_MAX(PMAX)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_raddr(cfg_raddr), .cfg_waddr(cfg_waddr), .cfg_iolen(cfg_iolen),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_time(cfg_time),
    .config_ena(config_ena), .config_addr(config_addr),
    .config_wdata(config_wdata), .config_rdata(config_rdata)
  );

  always #5 clk = ~clk;

  // Slave read path: data registered one cycle after the address.
  always @(posedge clk) begin
    case (config_addr)
      6'h21:   config_rdata <= {31'd0, (done_on != 0) && (poll_cnt_r >= done_on)};
      6'h22:   config_rdata <= slv_time;
      6'h3F:   config_rdata <= chk_val;
      default: config_rdata <= 32'h0;
    endcase
  end

  // Bus monitor, mid-cycle: writes, poll read starts, arm edges, done pulses.
  always @(negedge clk) begin
    cyc         <= cyc + 1;
    prev_addr_r <= config_addr;
    if (clr_mon) begin
      poll_cnt_r  <= 0;
      eoc_pulse_r <= 0;
      done_cnt_r  <= 0;
    end else begin
      if (config_addr == 6'h21 && prev_addr_r != 6'h21) begin
        poll_cnt_r <= poll_cnt_r + 1;
        poll_log.push_back(cyc);
      end
      if (config_ena) begin
        wr_log.push_back('{config_addr, config_wdata, cyc});
        if (config_addr == 6'h20) begin
          eoc_r <= config_wdata[0];
          if (config_wdata[0] && !eoc_r) eoc_pulse_r <= eoc_pulse_r + 1;
        end
      end
      if (cfg_done) done_cnt_r <= done_cnt_r + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1 clr_mon = 1'b1;
    wr_log.delete();
    poll_log.delete();
    @(posedge clk);
    #1 clr_mon = 1'b0;
  endtask

  // Drives a one-cycle start; t0 is the monitor label of the start cycle.
  task automatic start_run(input logic [31:0] ra, input logic [31:0] wa,
                           input logic [5:0] len, output int t0);
    @(negedge clk);
    cfg_raddr = ra;
    cfg_waddr = wa;
    cfg_iolen = len;
    cfg_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Returns at the negedge where cfg_done is seen; dcyc is that cycle's label.
  task automatic wait_done(input string tag, input int budget, output int dcyc);
    bit seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (cfg_done === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int td;
    logic [5:0]  ea[5] = '{6'h20, 6'h00, 6'h01, 6'h02, 6'h20};
    logic [31:0] ed[5] = '{32'h0, 32'h100, 32'h200, 32'd10, 32'h1};

    rst = 1'b0; cfg_start = 1'b0; cfg_raddr = 32'h0; cfg_waddr = 32'h0; cfg_iolen = 6'h0;
    done_on = 0; slv_time = 32'h1234; chk_val = 32'hF0F0_F0F0; clr_mon = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_flags", {cfg_busy, cfg_done, cfg_err, config_ena}, 4'b0000);
    chk("rst_addr", config_addr, 6'h0);
    chk("rst_wdata", config_wdata, 32'h0);
    chk("rst_time", cfg_time, 32'h0);
    rst = 1'b1;
    clear_mon();

    // Run 1: done on 3rd poll, CSR_TIME 0x1234.
    done_on = 3; slv_time = 32'h1234;
    start_run(32'h100, 32'h200, 6'd10, t0);
    chk("t1_busy", cfg_busy, 1'b1);
    wait_done("t1_done", 100, td);
    chk("t1_lat", td - t0, 25 + CHK);
    chk("t1_time", cfg_time, 32'h1234);
    chk("t1_err", cfg_err, 1'b0);
    @(negedge clk);
    chk("t1_after", {cfg_done, cfg_busy}, 2'b00);
    chk("t1_nwr", wr_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_log.size()) begin
        chk($sformatf("t1_wa%0d", i), wr_log[i].addr, ea[i]);
        chk($sformatf("t1_wd%0d", i), wr_log[i].data, ed[i]);
        chk($sformatf("t1_wc%0d", i), wr_log[i].cyc - t0, 1 + CHK + i);
      end
    end
    chk("t1_polls", poll_cnt_r, 3);
    for (int i = 0; i < 3; i++) begin
      if (i < poll_log.size()) chk($sformatf("t1_pc%0d", i), poll_log[i] - t0, 6 + CHK + 7 * i);
    end
    chk("t1_ndone", done_cnt_r, 1);

    // Run 2: DONE never set -> POLL_MAX reads then error, time stays 0.
    clear_mon();
    done_on = 0;
    start_run(32'h3000_0000, 32'h4000_0000, 6'd63, t0);
    wait_done("t2_done", 200, td);
    chk("t2_lat", td - t0, 58 + CHK);
    chk("t2_err", cfg_err, 1'b1);
    chk("t2_time", cfg_time, 32'h0);
    chk("t2_polls", poll_cnt_r, PMAX);
    chk("t2_nwr", wr_log.size(), 5);
    if (wr_log.size() > 3) chk("t2_iolen", wr_log[3].data, 32'd63);
    @(negedge clk);
    chk("t2_err_sticky", cfg_err, 1'b1);

    // Run 3: minimum latency, start during FINISH ignored, back-to-back re-arm.
    clear_mon();
    done_on = 1; slv_time = 32'hCAFE_0001;
    start_run(32'h10, 32'h20, 6'd1, t0);
    chk("t3_err_clr", cfg_err, 1'b0);
    wait_done("t3_done", 50, td);
    chk("t3_lat", td - t0, 11 + CHK);
    chk("t3_time", cfg_time, 32'hCAFE_0001);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("t3_fin_busy", cfg_busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("t3_fin_nwr", wr_log.size(), 5);
    slv_time = 32'h0000_0077;
    start_run(32'h11, 32'h22, 6'd2, t0);
    wait_done("t3b_done", 50, td);
    chk("t3b_lat", td - t0, 11 + CHK);
    chk("t3b_time", cfg_time, 32'h0000_0077);
    @(negedge clk);
    chk("t3b_nwr", wr_log.size(), 10);
    if (wr_log.size() == 10) begin
      chk("t3b_disarm", {wr_log[5].addr, wr_log[5].data}, {6'h20, 32'h0});
      chk("t3b_arm", {wr_log[9].addr, wr_log[9].data}, {6'h20, 32'h1});
    end
    chk("t3b_eoc_pulses", eoc_pulse_r, 2);
    chk("t3b_ndone", done_cnt_r, 2);

    // Run 4: second start mid-writes ignored, reset during POLL_WAIT aborts.
    clear_mon();
    done_on = 0;
    start_run(32'h500, 32'h600, 6'd5, t0);
    repeat (2) @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_nwr", wr_log.size(), 5);
    chk("t4_polls", poll_cnt_r, 1);
    chk("t4_busy", cfg_busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("t4_rst_flags", {cfg_busy, cfg_done, cfg_err, config_ena}, 4'b0000);
    chk("t4_rst_addr", config_addr, 6'h0);
    chk("t4_rst_time", cfg_time, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_no_done", done_cnt_r, 0);
    chk("t4_idle", cfg_busy, 1'b0);
    chk("t4_no_wr", wr_log.size(), 5);
    clear_mon();
    done_on = 1; slv_time = 32'h0000_0BAD;
    start_run(32'h700, 32'h800, 6'd7, t0);
    wait_done("t4b_done", 50, td);
    chk("t4b_lat", td - t0, 11 + CHK);
    chk("t4b_time", cfg_time, 32'h0000_0BAD);
    chk("t4b_err", cfg_err, 1'b0);

`ifdef SOFTMAX_CFG_CHECK_EN
    // Run 5: CSR_CHECK mismatch -> no writes, error, done 3 cycles after start.
    clear_mon();
    chk_val = 32'hDEAD_BEEF;
    start_run(32'h1, 32'h2, 6'd3, t0);
    wait_done("t5_done", 20, td);
    chk("t5_lat", td - t0, 3);
    chk("t5_err", cfg_err, 1'b1);
    chk("t5_time", cfg_time, 32'h0);
    @(negedge clk);
    chk("t5_nwr", wr_log.size(), 0);
    chk_val = 32'hF0F0_F0F0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
